mod_arbiter: RTL and testbench

- Shares one iterative 16/16 unsigned modulus unit among NREQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Latches the winning operands, drives a start/done handshake to the shared unit, and routes the remainder back to the winning requester.
- Sits between the client blocks and the single modulus datapath instance.

---
 rtl/mod_arbiter_if.sv | 33 +++
 rtl/mod_arbiter.sv | 141 ++++++++++++++
 tb/tb_mod_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_arbiter_if.sv
// Client-side and modulus-unit-side signals of mod_arbiter, bundled for port hookup.
// slave: the arbiter's view; master: the clients and modulus unit combined.
interface mod_arbiter_if #(
  parameter int IW = 2,
  parameter int W  = 16
);
  localparam int NREQ = 2 ** IW;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_dd;
  logic [NREQ*W-1:0] req_dv;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [W-1:0]      resp_rm;
  logic [NREQ-1:0]   resp_ready;
  logic              div_start;
  logic [W-1:0]      div_dd;
  logic [W-1:0]      div_dv;
  logic              div_done;
  logic [W-1:0]      div_rm;
  logic              busy;
  logic [15:0]       op_count;

  modport slave (
    input  req_valid, req_dd, req_dv, resp_ready, div_done, div_rm,
    output req_ready, resp_valid, resp_rm, div_start, div_dd, div_dv, busy, op_count
  );

  modport master (
    output req_valid, req_dd, req_dv, resp_ready, div_done, div_rm,
    input  req_ready, resp_valid, resp_rm, div_start, div_dd, div_dv, busy, op_count
  );
endinterface

// File: rtl/mod_arbiter.sv
// Round-robin front end sharing one iterative W/W modulus unit among 2**IW requesters.
// Define MOD_ARBITER_DVZERO_EN to answer zero-divisor requests locally (remainder = dividend).
module mod_arbiter #(
  parameter int IW = 2,
  parameter int W  = 16
) (
  input  logic         clk,
  input  logic         reset,
  mod_arbiter_if.slave bus
);
  localparam int unsigned NREQ = 2 ** IW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [W-1:0]    dd_q, dd_d;
  logic [W-1:0]    dv_q, dv_d;
  logic [W-1:0]    rm_q, rm_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            busy_q;

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   idx;
  logic [W-1:0]    sel_dd;
  logic [W-1:0]    sel_dv;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] rvalid;
  logic [W-1:0]    rm_out;
  logic            start;

  // Search upward from last_grant+1; IW-bit addition wraps modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = last_q + IW'(k);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign sel_dd = bus.req_dd[pick*W +: W];
  assign sel_dv = bus.req_dv[pick*W +: W];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    dd_d    = dd_q;
    dv_d    = dv_q;
    rm_d    = rm_q;
    cnt_d   = cnt_q;
    ready   = '0;
    rvalid  = '0;
    rm_out  = '0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        // reset term keeps the combinational accept strobe low while reset is held
        if (found && reset) begin
          ready[pick] = 1'b1;
          gnt_d       = pick;
          dd_d        = sel_dd;
          dv_d        = sel_dv;
`ifdef MOD_ARBITER_DVZERO_EN
          if (sel_dv == '0) begin
            rm_d    = sel_dd;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        start   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.div_done) begin
          rm_d    = bus.div_rm;
          state_d = RESP;
        end
      end
      RESP: begin
        rvalid[gnt_q] = 1'b1;
        rm_out        = rm_q;
        if (bus.resp_ready[gnt_q]) begin
          last_d  = gnt_q;
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= '1;
      gnt_q   <= '0;
      dd_q    <= '0;
      dv_q    <= '0;
      rm_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      dd_q    <= dd_d;
      dv_q    <= dv_d;
      rm_q    <= rm_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = rvalid;
  assign bus.resp_rm    = rm_out;
  assign bus.div_start  = start;
  assign bus.div_dd     = dd_q;
  assign bus.div_dv     = dv_q;
  assign bus.busy       = busy_q;
  assign bus.op_count   = cnt_q;
endmodule

// File: tb/tb_mod_arbiter.sv
// Self-checking bench for mod_arbiter: transaction-level model of grant order,
// remainder routing, handshake timing and op counting, plus a behavioural modulus unit.
module tb_mod_arbiter;
  localparam int IW   = 2;
  localparam int W    = 16;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spur = 1'b0;
  bit   lat_rand = 1'b0;

  mod_arbiter_if #(.IW(IW), .W(W)) bus ();
  mod_arbiter #(.IW(IW), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural modulus unit: answers some cycles after div_start (17 -> 18-cycle WAIT).
  int         ucnt;
  logic       udone;
  logic [W-1:0] urm;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ucnt  <= 0;
      udone <= 1'b0;
      urm   <= '0;
    end else begin
      udone <= 1'b0;
      if (bus.div_start) begin
        ucnt <= lat_rand ? int'($urandom_range(1, 20)) : 17;
        urm  <= (bus.div_dv == 0) ? bus.div_dd : bus.div_dd % bus.div_dv;
      end else if (ucnt != 0) begin
        ucnt <= ucnt - 1;
        if (ucnt == 1) udone <= 1'b1;
      end
    end
  end
  assign bus.div_done = udone | spur;
  assign bus.div_rm   = spur ? 16'hDEAD : urm;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // Reference model state
  int           m_last, m_cnt, m_g, m_age, starts, cyc;
  bit           m_inflight, m_have, m_bypass;
  logic [W-1:0] m_dd, m_dv, m_rm, last_rm;
  int           grant_log[$];
  int           grant_cyc[$];
  int           waited[NREQ];

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_dv();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 16'd1;
      2:       return 16'($urandom_range(2, 15));
      default: return 16'($urandom_range(1, 65535));
    endcase
  endfunction

  task automatic raise(input int i, input logic [W-1:0] dd, input logic [W-1:0] dv);
    bus.req_valid[i]       = 1'b1;
    bus.req_dd[i*W +: W]   = dd;
    bus.req_dv[i*W +: W]   = dv;
  endtask

  // One clock: check outputs at negedge, advance the model across the posedge.
  task automatic step();
    logic [NREQ-1:0] exp_ready, exp_rv;
    logic [W-1:0]    gdd, gdv;
    int              w, g_obs;
    bit              done_now, accept_now;
    @(negedge clk);
    exp_ready = '0;
    w = -1;
    gdd = '0;
    gdv = '0;
    if (!m_inflight && bus.req_valid != 0) begin
      w = rr_pick(bus.req_valid, m_last);
      exp_ready[w] = 1'b1;
      gdd = bus.req_dd[w*W +: W];
      gdv = bus.req_dv[w*W +: W];
    end
    check("req_ready", bus.req_ready, exp_ready);
    check("busy", bus.busy, m_inflight);
    check("op_count", bus.op_count, m_cnt);
    exp_rv = '0;
    if (m_have) exp_rv[m_g] = 1'b1;
    check("resp_valid", bus.resp_valid, exp_rv);
    check("resp_rm", bus.resp_rm, m_have ? m_rm : '0);
    check("div_start", bus.div_start, m_inflight && !m_bypass && m_age == 1);
    if (bus.div_start) begin
      starts++;
      check("div_dd", bus.div_dd, m_dd);
      check("div_dv", bus.div_dv, m_dv);
    end
    g_obs = -1;
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g_obs = i;
    if (g_obs >= 0) begin
      check("fair_wait", waited[g_obs] <= NREQ - 1, 1);
      for (int i = 0; i < NREQ; i++)
        if (i != g_obs && bus.req_valid[i]) waited[i]++;
      waited[g_obs] = 0;
    end
    done_now   = m_inflight && !m_have && !m_bypass && m_age >= 2 && bus.div_done;
    accept_now = m_have && bus.resp_ready[m_g];
    if (accept_now) last_rm = bus.resp_rm;
    @(posedge clk);
    #1;
    cyc++;
    if (w >= 0) begin
      m_inflight = 1'b1;
      m_g        = w;
      m_dd       = gdd;
      m_dv       = gdv;
      m_age      = 1;
      starts     = 0;
      m_bypass   = 1'b0;
      grant_log.push_back(w);
      grant_cyc.push_back(cyc);
`ifdef MOD_ARBITER_DVZERO_EN
      if (gdv == 0) begin
        m_bypass = 1'b1;
        m_have   = 1'b1;
        m_rm     = gdd;
      end
`endif
      bus.req_valid[w] = 1'b0;
    end else if (m_inflight) begin
      m_age++;
    end
    if (done_now) begin
      m_have = 1'b1;
      m_rm   = (m_dv == 0) ? m_dd : m_dd % m_dv;
    end
    if (accept_now) begin
      m_inflight = 1'b0;
      m_have     = 1'b0;
      m_last     = m_g;
      m_cnt      = (m_cnt + 1) & 16'hFFFF;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    bus.req_valid  = '0;
    bus.resp_ready = '0;
    spur           = 1'b0;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rm", bus.resp_rm, 0);
    check("rst_div_start", bus.div_start, 0);
    check("rst_div_dd", bus.div_dd, 0);
    check("rst_div_dv", bus.div_dv, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_op_count", bus.op_count, 0);
    m_last = NREQ - 1;
    m_cnt = 0; m_g = 0; m_age = 0; starts = 0;
    m_inflight = 1'b0; m_have = 1'b0; m_bypass = 1'b0;
    grant_log.delete();
    grant_cyc.delete();
    for (int i = 0; i < NREQ; i++) waited[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_until_idle(input int budget);
    for (int n = 0; n < budget && (m_inflight || bus.req_valid != 0); n++) step();
    check("drain_timeout", bus.busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rm0;
    bus.req_valid  = '0;
    bus.req_dd     = '0;
    bus.req_dv     = '0;
    bus.resp_ready = '0;
    cyc = 0;
    last_rm = '0;
    #3;
    do_reset();

    // Single request
    bus.resp_ready = '1;
    raise(0, 16'd100, 16'd7);
    run_until_idle(100);
    check("single_rm", last_rm, 16'd2);
    check("single_starts", starts, 1);
    check("single_count", bus.op_count, 1);

    // Spurious done in IDLE
    spur = 1'b1;
    step();
    step();
    spur = 1'b0;
    step();
    check("spur_idle_busy", bus.busy, 0);

    // Response backpressure with spurious done and foreign resp_ready in RESP
    bus.resp_ready = '0;
    raise(1, 16'd5000, 16'd37);
    for (int n = 0; n < 100 && !m_have; n++) step();
    rm0 = bus.resp_rm;
    check("bp_rm", rm0, 16'd5);
    raise(3, 16'd77, 16'd10);
    for (int n = 0; n < 10; n++) begin
      spur = (n == 3);
      if (n >= 6) bus.resp_ready = 4'b1101;
      step();
      check("bp_rm_stable", bus.resp_rm, rm0);
      check("bp_busy", bus.busy, 1);
    end
    spur = 1'b0;
    bus.resp_ready = '1;
    run_until_idle(100);
    check("bp_next_rm", last_rm, 16'd7);

    // Zero divisor
    raise(3, 16'h1234, 16'h0000);
    run_until_idle(100);
    check("dvzero_rm", last_rm, 16'h1234);
`ifdef MOD_ARBITER_DVZERO_EN
    check("dvzero_starts", starts, 0);
`else
    check("dvzero_starts", starts, 1);
`endif

    // Contention from reset
    do_reset();
    bus.resp_ready = '1;
    for (int i = 0; i < NREQ; i++) raise(i, 16'($urandom), 16'($urandom_range(1, 65535)));
    for (int n = 0; n < 200 && grant_log.size() < 5; n++) begin
      step();
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_valid[i]) raise(i, 16'($urandom), 16'($urandom_range(1, 65535)));
    end
    bus.req_valid = '0;
    run_until_idle(100);
    check("rr_grants", grant_log.size(), 5);
    if (grant_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("rr_order", grant_log[i], i % NREQ);
      for (int i = 1; i < 5; i++) check("rr_gap", grant_cyc[i] - grant_cyc[i-1], 21);
    end

    // Reset during WAIT; last grant was 0, so only a true reset makes 0 win next
    raise(2, 16'd999, 16'd13);
    for (int n = 0; n < 50 && !(m_inflight && m_age >= 6); n++) step();
    check("wait_busy", bus.busy, 1);
    do_reset();
    bus.resp_ready = '1;
    for (int i = 0; i < NREQ; i++) raise(i, 16'($urandom), 16'($urandom_range(1, 65535)));
    for (int n = 0; n < 20 && grant_log.size() == 0; n++) step();
    check("post_rst_grants", grant_log.size(), 1);
    if (grant_log.size() >= 1) check("post_rst_first", grant_log[0], 0);
    bus.req_valid = '0;
    run_until_idle(100);

    // Random traffic
    lat_rand = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      bus.resp_ready = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 7) == 0) raise(i, 16'($urandom), rnd_dv());
      step();
    end
    bus.req_valid  = '0;
    bus.resp_ready = '1;
    run_until_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
